// File: rtl/first_event_race_checker.sv
// first_event_race_checker
// Run-time monitor for the rule "a trigger rise is followed by the first of
// N event rises, and that winning event selects the expected data value".
// After a trigger it waits for the first event rise and compares obs_i with
// that event's expected slice. It reports pass or fail with a reason code,
// the index of the winning event and saturating pass/fail counters.
// It also detects timeouts and events that rise on the same edge (ties).

module first_event_race_checker #(
   parameter int N_EVT      = 2,
   parameter int DW         = 1,
   parameter int TIMEOUT    = 16,
   parameter int TIE_POLICY = 0,
   parameter int CNT_W      = 16
) (
   input  logic                                       clk,
   input  logic                                       rst_n,
   input  logic                                       en,
   input  logic                                       trig_i,
   input  logic [N_EVT-1:0]                           evt_i,
   input  logic [DW-1:0]                              obs_i,
   input  logic [N_EVT*DW-1:0]                        exp_i,
   input  logic                                       clr_cnt_i,
   output logic                                       busy_o,
   output logic                                       pass_o,
   output logic                                       fail_o,
   output logic [1:0]                                 fail_code_o,
   output logic [((N_EVT > 1) ? $clog2(N_EVT) : 1)-1:0] winner_o,
   output logic [CNT_W-1:0]                           pass_cnt_o,
   output logic [CNT_W-1:0]                           fail_cnt_o
);

   localparam int WW  = (N_EVT > 1) ? $clog2(N_EVT) : 1;
   localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   // Counter value seen on the edge where the timeout fires (Nth edge after trigger)
   localparam logic [TCW-1:0] TO_LAST = (TIMEOUT > 0) ? TCW'(TIMEOUT - 1) : {TCW{1'b0}};

   localparam logic [1:0] CODE_NONE     = 2'd0;
   localparam logic [1:0] CODE_MISMATCH = 2'd1;
   localparam logic [1:0] CODE_TIE      = 2'd2;
   localparam logic [1:0] CODE_TIMEOUT  = 2'd3;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t            state_r;
   logic              trig_prev_r;
   logic [N_EVT-1:0]  evt_prev_r;
   logic [TCW-1:0]    wait_cnt_r;

   logic              trig_rise_s;
   logic [N_EVT-1:0]  evt_rise_s;
   logic [WW-1:0]     win_idx_s;
   logic              multi_s;
   logic              match_s;
   logic              timeout_hit_s;
   logic              rep_pass_s;
   logic              rep_fail_s;
   logic [1:0]        rep_code_s;
   logic [WW-1:0]     rep_win_s;

   // Index of the lowest set bit; 0 when no bit is set
   function automatic logic [WW-1:0] lowest_idx(input logic [N_EVT-1:0] v);
      logic [WW-1:0] idx;
      idx = {WW{1'b0}};
      for (int k = N_EVT - 1; k >= 0; k--) begin
         if (v[k]) begin
            idx = WW'(k);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   // True when two or more bits are set
   function automatic logic more_than_one(input logic [N_EVT-1:0] v);
      return ((v & (v - {{(N_EVT-1){1'b0}}, 1'b1})) != {N_EVT{1'b0}});
   endfunction

   // Edge detection and the decision taken on this edge while waiting
   always_comb begin
      trig_rise_s   = trig_i & ~trig_prev_r;
      evt_rise_s    = evt_i & ~evt_prev_r;
      win_idx_s     = lowest_idx(evt_rise_s);
      multi_s       = more_than_one(evt_rise_s);
      match_s       = (obs_i == exp_i[win_idx_s*DW +: DW]);
      timeout_hit_s = (TIMEOUT != 0) && (wait_cnt_r == TO_LAST);
      rep_pass_s    = 1'b0;
      rep_fail_s    = 1'b0;
      rep_code_s    = CODE_NONE;
      rep_win_s     = win_idx_s;
      if ((state_r == ST_WAIT) && en) begin
         if (|evt_rise_s) begin
            // An event rise takes precedence over a timeout on the same edge
            if (multi_s && (TIE_POLICY == 0)) begin
               rep_fail_s = 1'b1;
               rep_code_s = CODE_TIE;
            end else if (match_s) begin
               rep_pass_s = 1'b1;
            end else begin
               rep_fail_s = 1'b1;
               rep_code_s = CODE_MISMATCH;
            end
         end else if (timeout_hit_s) begin
            rep_fail_s = 1'b1;
            rep_code_s = CODE_TIMEOUT;
            rep_win_s  = {WW{1'b0}};
         end else begin
            rep_fail_s = 1'b0;
         end
      end else begin
         rep_pass_s = 1'b0;
      end
   end

   // Check FSM with registered report outputs and previous-value samples
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         trig_prev_r <= 1'b0;
         evt_prev_r  <= {N_EVT{1'b0}};
         wait_cnt_r  <= {TCW{1'b0}};
         busy_o      <= 1'b0;
         pass_o      <= 1'b0;
         fail_o      <= 1'b0;
         fail_code_o <= CODE_NONE;
         winner_o    <= {WW{1'b0}};
      end else begin
         trig_prev_r <= trig_i;
         evt_prev_r  <= evt_i;
         pass_o      <= 1'b0;
         fail_o      <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               // Event rises here are ignored, including those on the trigger edge
               if (en && trig_rise_s) begin
                  state_r    <= ST_WAIT;
                  busy_o     <= 1'b1;
                  wait_cnt_r <= {TCW{1'b0}};
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_WAIT: begin
               // A further trigger rise here is ignored; there is no restart
               if (!en) begin
                  state_r <= ST_IDLE;
                  busy_o  <= 1'b0;
               end else if (rep_pass_s || rep_fail_s) begin
                  state_r     <= ST_IDLE;
                  busy_o      <= 1'b0;
                  pass_o      <= rep_pass_s;
                  fail_o      <= rep_fail_s;
                  fail_code_o <= rep_code_s;
                  winner_o    <= rep_win_s;
               end else begin
                  wait_cnt_r <= wait_cnt_r + TCW'(1);
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_o  <= 1'b0;
            end
         endcase
      end
   end

   // Saturating pass/fail statistics; a clear beats a same-edge increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pass_cnt_o <= {CNT_W{1'b0}};
         fail_cnt_o <= {CNT_W{1'b0}};
      end else if (clr_cnt_i) begin
         pass_cnt_o <= {CNT_W{1'b0}};
         fail_cnt_o <= {CNT_W{1'b0}};
      end else begin
         if (rep_pass_s && !(state_r != ST_WAIT) && (pass_cnt_o != {CNT_W{1'b1}})) begin
            pass_cnt_o <= pass_cnt_o + CNT_W'(1);
         end else begin
            pass_cnt_o <= pass_cnt_o;
         end
         if (rep_fail_s && !(state_r != ST_WAIT) && (fail_cnt_o != {CNT_W{1'b1}})) begin
            fail_cnt_o <= fail_cnt_o + CNT_W'(1);
         end else begin
            fail_cnt_o <= fail_cnt_o;
         end
      end
   end

endmodule

// File: tb/tb_first_event_race_checker.sv
// Directed self-checking bench for first_event_race_checker.
// dut0: TIMEOUT=4, ties fail.
// dut1: TIMEOUT=4, lowest index wins on a tie, 2-bit counters.
// Only one instance is enabled at a time.

module tb_first_event_race_checker;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en0, en1;
   logic       trig;
   logic [1:0] evt;
   logic [0:0] obs;
   logic [1:0] exp_v;
   logic       clr;

   logic       b0, p0, f0;
   logic [1:0] fc0;
   logic [0:0] w0;
   logic [15:0] pc0, fcn0;
   logic       b1, p1, f1;
   logic [1:0] fc1;
   logic [0:0] w1;
   logic [1:0] pc1, fcn1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   first_event_race_checker #(.N_EVT(2), .DW(1), .TIMEOUT(4), .TIE_POLICY(0), .CNT_W(16)) dut0 (
      .clk(clk), .rst_n(rst_n), .en(en0), .trig_i(trig), .evt_i(evt), .obs_i(obs),
      .exp_i(exp_v), .clr_cnt_i(clr), .busy_o(b0), .pass_o(p0), .fail_o(f0),
      .fail_code_o(fc0), .winner_o(w0), .pass_cnt_o(pc0), .fail_cnt_o(fcn0));

   first_event_race_checker #(.N_EVT(2), .DW(1), .TIMEOUT(4), .TIE_POLICY(1), .CNT_W(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .en(en1), .trig_i(trig), .evt_i(evt), .obs_i(obs),
      .exp_i(exp_v), .clr_cnt_i(clr), .busy_o(b1), .pass_o(p1), .fail_o(f1),
      .fail_code_o(fc1), .winner_o(w1), .pass_cnt_o(pc1), .fail_cnt_o(fcn1));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic go_idle();
      trig = 1'b0;
      evt  = 2'b00;
      obs  = 1'b0;
      step();
   endtask

   // Trigger edge, then the given event pattern/obs on the following edge
   task automatic trig_then_evt(input logic [1:0] pat, input logic o);
      trig = 1'b1;
      step();
      trig = 1'b0;
      evt  = pat;
      obs  = o;
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en0 = 1'b0; en1 = 1'b0; trig = 1'b0; evt = 2'b00;
      obs = 1'b0; exp_v = 2'b01; clr = 1'b0;
      #12;
      checks++; if ({b0, p0, f0, fc0, w0} !== 6'd0) begin errors++; $display("FAIL reset_flags got=%b want=0", {b0, p0, f0, fc0, w0}); end
      checks++; if ({pc0, fcn0} !== 32'd0) begin errors++; $display("FAIL reset_cnt got=%h want=0", {pc0, fcn0}); end
      rst_n = 1'b1;
      en0 = 1'b1;
      step();
   endtask

   task automatic test_pass();
      trig = 1'b1;
      step();
      checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL pass_busy got=%b want=1", b0); end
      trig = 1'b0;
      step();
      checks++; if ({p0, f0} !== 2'b00) begin errors++; $display("FAIL pass_early got=%b want=00", {p0, f0}); end
      evt = 2'b01; obs = 1'b1;
      step();
      checks++; if ({p0, f0, b0} !== 3'b100) begin errors++; $display("FAIL pass_pulse got=%b want=100", {p0, f0, b0}); end
      checks++; if (w0 !== 1'b0 || pc0 !== 16'd1) begin errors++; $display("FAIL pass_win_cnt got=%0d/%0d want=0/1", w0, pc0); end
      step();
      checks++; if (p0 !== 1'b0) begin errors++; $display("FAIL pass_one_cycle got=%b want=0", p0); end
      go_idle();
   endtask

   task automatic test_mismatch();
      trig_then_evt(2'b10, 1'b1);
      checks++; if ({p0, f0, fc0, w0} !== 5'b01011) begin errors++; $display("FAIL mismatch got=%b want=01011", {p0, f0, fc0, w0}); end
      checks++; if (fcn0 !== 16'd1) begin errors++; $display("FAIL mismatch_cnt got=%0d want=1", fcn0); end
      go_idle();
      trig_then_evt(2'b10, 1'b0);
      checks++; if ({p0, f0, fc0, w0} !== 5'b10001) begin errors++; $display("FAIL evt1_pass got=%b want=10001", {p0, f0, fc0, w0}); end
      checks++; if (pc0 !== 16'd2) begin errors++; $display("FAIL evt1_pass_cnt got=%0d want=2", pc0); end
      go_idle();
   endtask

   task automatic test_tie();
      trig_then_evt(2'b11, 1'b1);
      checks++; if ({p0, f0, fc0, w0} !== 5'b01100) begin errors++; $display("FAIL tie got=%b want=01100", {p0, f0, fc0, w0}); end
      checks++; if (fcn0 !== 16'd2) begin errors++; $display("FAIL tie_cnt got=%0d want=2", fcn0); end
      go_idle();
   endtask

   task automatic test_timeout();
      trig = 1'b1;
      step();
      trig = 1'b0;
      step(); step(); step();
      checks++; if ({f0, b0} !== 2'b01) begin errors++; $display("FAIL to_early got=%b want=01", {f0, b0}); end
      step();
      checks++; if ({f0, fc0, w0, b0} !== 5'b11100) begin errors++; $display("FAIL timeout got=%b want=11100", {f0, fc0, w0, b0}); end
      checks++; if (fcn0 !== 16'd3) begin errors++; $display("FAIL timeout_cnt got=%0d want=3", fcn0); end
      go_idle();
      trig = 1'b1;
      step();
      trig = 1'b0;
      step(); step(); step();
      evt = 2'b01; obs = 1'b1;
      step();
      checks++; if ({p0, f0, fc0} !== 4'b1000) begin errors++; $display("FAIL evt_beats_to got=%b want=1000", {p0, f0, fc0}); end
      checks++; if (pc0 !== 16'd3 || fcn0 !== 16'd3) begin errors++; $display("FAIL evt_beats_to_cnt got=%0d/%0d want=3/3", pc0, fcn0); end
      go_idle();
   endtask

   task automatic test_ignored();
      // Event rising with the trigger and staying high is never counted
      trig = 1'b1; evt = 2'b01; obs = 1'b1;
      step();
      step();
      checks++; if ({p0, f0, b0} !== 3'b001) begin errors++; $display("FAIL evt_with_trig got=%b want=001", {p0, f0, b0}); end
      en0 = 1'b0;
      step();
      checks++; if ({p0, f0, b0} !== 3'b000) begin errors++; $display("FAIL en_abort got=%b want=000", {p0, f0, b0}); end
      checks++; if (pc0 !== 16'd3 || fcn0 !== 16'd3) begin errors++; $display("FAIL en_abort_cnt got=%0d/%0d want=3/3", pc0, fcn0); end
      en0 = 1'b1;
      go_idle();
      // Second trigger rise in WAIT must not restart the timeout
      trig = 1'b1;
      step();
      trig = 1'b0;
      step();
      trig = 1'b1;
      step();
      step();
      checks++; if ({f0, b0} !== 2'b01) begin errors++; $display("FAIL retrig_early got=%b want=01", {f0, b0}); end
      step();
      checks++; if ({f0, fc0} !== 3'b111) begin errors++; $display("FAIL retrig_no_restart got=%b want=111", {f0, fc0}); end
      go_idle();
   endtask

   task automatic test_async_reset();
      trig = 1'b1;
      step();
      checks++; if (b0 !== 1'b1 || fcn0 !== 16'd4) begin errors++; $display("FAIL pre_rst got=%b/%0d want=1/4", b0, fcn0); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({b0, p0, f0, fc0, w0} !== 6'd0) begin errors++; $display("FAIL async_rst_flags got=%b want=0", {b0, p0, f0, fc0, w0}); end
      checks++; if ({pc0, fcn0} !== 32'd0) begin errors++; $display("FAIL async_rst_cnt got=%h want=0", {pc0, fcn0}); end
      trig = 1'b0;
      #1 rst_n = 1'b1;
      step();
   endtask

   task automatic test_clr_cnt();
      trig_then_evt(2'b01, 1'b1);
      checks++; if (pc0 !== 16'd1) begin errors++; $display("FAIL clr_pre got=%0d want=1", pc0); end
      go_idle();
      trig = 1'b1;
      step();
      trig = 1'b0; evt = 2'b01; obs = 1'b1; clr = 1'b1;
      step();
      clr = 1'b0;
      checks++; if (p0 !== 1'b1 || pc0 !== 16'd0) begin errors++; $display("FAIL clr_wins got=%b/%0d want=1/0", p0, pc0); end
      go_idle();
   endtask

   task automatic test_tie_lowest();
      en0 = 1'b0; en1 = 1'b1;
      trig_then_evt(2'b11, 1'b1);
      checks++; if ({p1, f1, fc1, w1} !== 5'b10000) begin errors++; $display("FAIL tie_lowest got=%b want=10000", {p1, f1, fc1, w1}); end
      checks++; if (pc1 !== 2'd1) begin errors++; $display("FAIL tie_lowest_cnt got=%0d want=1", pc1); end
      go_idle();
   endtask

   task automatic test_saturate();
      logic [1:0] want;
      for (int i = 2; i <= 5; i++) begin
         trig_then_evt(2'b01, 1'b1);
         want = (i > 3) ? 2'd3 : 2'(i);
         checks++; if (p1 !== 1'b1 || pc1 !== want) begin errors++; $display("FAIL saturate_%0d got=%b/%0d want=1/%0d", i, p1, pc1, want); end
         go_idle();
      end
   endtask

   initial begin
      test_reset();
      test_pass();
      test_mismatch();
      test_tie();
      test_timeout();
      test_ignored();
      test_async_reset();
      test_clr_cnt();
      test_tie_lowest();
      test_saturate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/first_event_race_checker.md
Name: first_event_race_checker

Overview:
- Synthesizable, parametrised run-time monitor for the "trigger, then first-of-N events decides the expected data value" protocol rule.
- On a rising edge of trig_i it waits for the first rising edge among N_EVT event lines.
- It then checks obs_i against the expected value programmed for the winning event and reports pass/fail with a reason code and counters.
- It sits beside the DUT in the bench or in emulation images as a hardware companion to the team's SVA checkers, adding timeout, tie detection and statistics.

Parameters:
N_EVT, 2, number of candidate event lines (2..8)
DW, 1, width of observed/expected data
TIMEOUT, 16, max cycles waited after trigger; 0 disables timeout
TIE_POLICY, 0, 0 = simultaneous event rises fail with TIE; 1 = lowest index wins
CNT_W, 16, width of pass/fail counters

Ports:
clk  in  1  clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
en  in  1  checker enable
trig_i  in  1  trigger line, rising edge starts a check
evt_i  in  N_EVT  candidate event lines
obs_i  in  DW  observed value checked at the deciding edge
exp_i  in  N_EVT*DW  expected value per event, slice k = exp_i[k*DW +: DW]
clr_cnt_i  in  1  synchronous clear of both counters
busy_o  out  1  high while in WAIT
pass_o  out  1  one-cycle pass pulse
fail_o  out  1  one-cycle fail pulse
fail_code_o  out  2  0 none, 1 MISMATCH, 2 TIE, 3 TIMEOUT; held until next report
winner_o  out  clog2(N_EVT) (min 1)  index of deciding event; held until next report
pass_cnt_o  out  CNT_W  saturating pass count
fail_cnt_o  out  CNT_W  saturating fail count

Behaviour:
- Reset (rst_n low, async): state IDLE; every output 0; the trig and evt previous-value registers are 0.
  - A line that is already high at the first post-reset edge therefore counts as a rise.
- Edge detection: rise = current sample & ~previous-sample registered value. Previous-value registers update every cycle regardless of state or en.
- IDLE:
  - A trig rise with en=1 moves to WAIT, sets busy_o and clears the wait counter.
  - Event rises seen in IDLE are ignored, including those on the same edge as the trig rise. Events count from the next edge onward.
- WAIT, evaluated each edge in this priority:
  1. en=0: abort to IDLE with no report.
  2. Exactly one event k rises:
     - obs_i == exp slice k gives pass.
     - Otherwise fail, code MISMATCH.
     - winner_o = k.
  3. Two or more events rise:
     - TIE_POLICY=0: fail, code TIE, winner_o = lowest rising index.
     - TIE_POLICY=1: treat the lowest index as the sole winner and proceed as rule 2.
  4. No rise, TIMEOUT != 0, and the wait counter equals TIMEOUT-1: fail, code TIMEOUT, winner_o = 0.
  5. Otherwise: increment the wait counter and stay in WAIT.
- Reporting edge: on any report the block returns to IDLE and clears busy_o.
  - pass_o or fail_o is high for exactly the cycle following the deciding edge (registered, latency 1).
  - A trig rise on the deciding edge is ignored. A new check needs a fresh rise later.
- A trig rise while already in WAIT is ignored; there is no restart.
- Timeout timing: TIMEOUT=N fails at the Nth edge after the trigger edge when no event has risen. An event rise on that same edge wins over the timeout.
- Counters:
  - pass_cnt_o and fail_cnt_o increment on the report edge and saturate at all-ones.
  - clr_cnt_i clears both and wins over a simultaneous increment.
- fail_code_o is set to 0 by a pass report.

Test Plan:
- N_EVT=2, DW=1, exp={evt1:0, evt0:1}: trig rise at edge 10, evt0 rise at edge 12 with obs=1 -> pass_o at cycle 13, winner_o=0, pass_cnt_o=1.
- Same config: trig rise, then evt1 rise with obs=1 -> fail_o pulse, fail_code_o=1, winner_o=1, fail_cnt_o=1. Repeat with obs=0 -> pass.
- Both events rise on the same edge: TIE_POLICY=0 gives fail_code_o=2 and winner_o=0; TIE_POLICY=1 with obs=1 gives a pass with winner 0.
- TIMEOUT=4, trig at edge 20, no events -> fail at edge 24, code 3. Again with evt0 rising at edge 24 -> event wins, no timeout.
- Events before/with the trigger, a second trig in WAIT, and en dropped mid-WAIT -> no report, busy_o falls, counters unchanged.
- Async rst_n asserted mid-WAIT -> all outputs 0 immediately. Also: clr_cnt_i on a pass edge leaves pass_cnt_o at 0, and with CNT_W=2, 5 passes saturate pass_cnt_o at 3.
